// File: rtl/operand_read.sv
// operand_read: decode-side operand fetch with write-back bypass, a 32-entry
// pending-write scoreboard for RAW/WAW hazards, and a valid/ready output
// register feeding EX.
module operand_read (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  AA,
  input  logic [4:0]  BA,
  input  logic [4:0]  DA,
  input  logic        RW,
  input  logic [1:0]  MD,
  output logic [4:0]  rf_AA,
  output logic [4:0]  rf_BA,
  input  logic [31:0] rf_A,
  input  logic [31:0] rf_B,
  input  logic        wb_RW,
  input  logic [4:0]  wb_DA,
  input  logic [31:0] wb_BusD,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [4:0]  ex_DA,
  output logic        ex_RW,
  output logic [1:0]  ex_MD,
  output logic [15:0] stall_cycles
);

  logic [31:0] pending, pending_nxt;
  logic [31:0] op_a, op_b;
  logic        blk_a, blk_b, blk_d, slot_free, issue;

  assign rf_AA = AA;
  assign rf_BA = BA;

  // Operand select: r0 is hard zero, same-cycle write-back beats the array.
  always_comb begin
    op_a = rf_A;
    op_b = rf_B;
    if (wb_RW && wb_DA == AA && wb_DA != 5'd0) op_a = wb_BusD;
    if (wb_RW && wb_DA == BA && wb_DA != 5'd0) op_b = wb_BusD;
    if (AA == 5'd0) op_a = 32'd0;
    if (BA == 5'd0) op_b = 32'd0;
  end

  // Hazard detection; a write-back landing this cycle releases the hazard
  // because the bypass supplies the data and frees the scoreboard entry.
  always_comb begin
    blk_a     = (AA != 5'd0) && pending[AA] && !(wb_RW && wb_DA == AA);
    blk_b     = (BA != 5'd0) && pending[BA] && !(wb_RW && wb_DA == BA);
    blk_d     = RW && (DA != 5'd0) && pending[DA] && !(wb_RW && wb_DA == DA);
    slot_free = !ex_valid || ex_ready;
    id_ready  = slot_free && !flush && !blk_a && !blk_b && !blk_d;
    issue     = id_valid && id_ready;
  end

  // Scoreboard update: write-back clears, issue re-arms (WAW), flush of the
  // held producer clears last so it overrides everything for that index.
  always_comb begin
    pending_nxt = pending;
    if (wb_RW && wb_DA != 5'd0) pending_nxt[wb_DA] = 1'b0;
    if (issue && RW && DA != 5'd0) pending_nxt[DA] = 1'b1;
    if (flush && ex_valid && ex_RW && ex_DA != 5'd0) pending_nxt[ex_DA] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // EX output register: load on issue, drain on flush or consumer accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_A     <= '0;
      ex_B     <= '0;
      ex_DA    <= '0;
      ex_RW    <= 1'b0;
      ex_MD    <= '0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_A     <= op_a;
      ex_B     <= op_b;
      ex_DA    <= DA;
      ex_RW    <= RW;
      ex_MD    <= MD;
    end else if (flush || ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was held back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 stall_cycles <= '0;
    else if (id_valid && !id_ready && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: doc/operand_read.md
# operand_read

Decode-side operand read stage for the 32-bit pipelined CPU: the read end of the register-file interface whose write end is the write-back stage. It drives the register-file read addresses and bypasses same-cycle write-back data. A 32-entry pending-write scoreboard holds RAW/WAW hazards, and the operands are registered into the EX stage under a valid/ready handshake.

## Interface
- No parameters; data width 32, register address width 5, fixed.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decoded instruction present
- id_ready  out  1  instruction accepted this cycle (combinational)
- AA, BA  in  5  source register addresses
- DA  in  5  destination register address
- RW  in  1  instruction writes DA
- MD  in  2  write-back select, passed through (00 ALU, 01 load, 10 NxorV)
- rf_AA, rf_BA  out  5  register-file read addresses (= AA, BA, combinational)
- rf_A, rf_B  in  32  register-file read data (combinational from rf_AA/rf_BA)
- wb_RW, wb_DA, wb_BusD  in  1/5/32  write-back port as seen by the register file this cycle
- flush  in  1  drop the instruction held in the output register
- ex_ready  in  1  EX accepts ex_* this cycle
- ex_valid  out  1  output register holds an instruction
- ex_A, ex_B  out  32  operands
- ex_DA, ex_RW, ex_MD  out  5/1/2  destination info, passed through
- stall_cycles  out  16  saturating count of cycles with id_valid=1 and id_ready=0

## Operation
- Register 0 reads as 0, is never marked pending, and never blocks.
- Operand mux, per source S in {AA, BA}:
  - S==0 -> 0.
  - Otherwise, if wb_RW && wb_DA==S && wb_DA!=0 -> wb_BusD.
  - Otherwise -> rf_A or rf_B.
- pending[31:0] scoreboard: one outstanding write per register.
- Source S is blocked when S!=0 && pending[S] && !(wb_RW && wb_DA==S).
- Destination is blocked when RW && DA!=0 && pending[DA] && !(wb_RW && wb_DA==DA).
- slot_free = !ex_valid || ex_ready.
- id_ready = slot_free && !flush && no source blocked && destination not blocked. It does not depend on id_valid.
- issue = id_valid && id_ready. On issue, load ex_A, ex_B, ex_DA, ex_RW, ex_MD and set ex_valid=1.
- On issue with RW && DA!=0, set pending[DA].
- No issue but ex_ready: clear ex_valid. The other ex_* fields hold.
- Write-back with wb_RW && wb_DA!=0: clear pending[wb_DA].
- Same-index set and clear in one cycle: set wins (a WAW issue re-arms the bit).
- flush: clear ex_valid. If ex_valid && ex_RW && ex_DA!=0, clear pending[ex_DA]. This clear wins over a write-back set to the same index; set cannot occur because issue is blocked during flush.
- stall_cycles increments when id_valid && !id_ready, and saturates at 0xFFFF.

## Timing
- Reset values: ex_valid=0, ex_A=0, ex_B=0, ex_DA=0, ex_RW=0, ex_MD=00, pending=0, stall_cycles=0. Reset takes effect asynchronously.
- Issue-to-ex_valid latency: 1 cycle. Back-to-back issue at 1/cycle when ex_ready=1 and there are no hazards.
- A consumer of a producer issued at cycle t stalls until the cycle when the producer's write-back appears on wb_*. It issues in that cycle, using wb_BusD bypass.
- ex_* hold stable while ex_valid && !ex_ready.
- Reset mid-operation discards the held instruction and all pending bits.

## Test plan
- Reset, then hold id_valid=0 -> all outputs at reset values; id_ready=1.
- Issue AA=1, BA=2, DA=3, RW=1 with rf_A=0x11, rf_B=0x22 -> next cycle ex_valid=1, ex_A=0x11, ex_B=0x22, ex_DA=3; pending[3]=1.
- Issue a reader with AA=3 while pending[3] is set -> id_ready=0 and stall_cycles counts up. When wb_RW=1, wb_DA=3, wb_BusD=0xDEADBEEF -> it issues that cycle with ex_A=0xDEADBEEF, and pending[3] clears.
- ex_ready=0 with ex_valid=1 -> id_ready=0 and ex_* unchanged for 3 cycles. Raise ex_ready -> the next instruction loads.
- AA=0 with rf_A=0xFFFFFFFF and wb_DA=0, wb_RW=1 -> ex_A=0; a write with DA=0 never sets pending.
- flush while ex_DA=5, ex_RW=1 -> ex_valid=0 and pending[5]=0 next cycle; an instruction with AA=5 then issues without waiting.
